// File: rtl/mmu_pkg.sv
// Shared types and widths for the mmu command sequencer.
package mmu_pkg;

  localparam int unsigned ELEM_W = 8;
  localparam int unsigned ACC_W  = 32;

  typedef enum logic [3:0] {
    IDLE,
    W_PUSH,
    W_LOAD,
    W_WAIT,
    SWAP,
    D_PUSH,
    RUN,
    M_WAIT,
    POP,
    CAP,
    ERR
  } seq_state_t;

endpackage

// File: rtl/seq_timeout.sv
// Stall-cycle counter: clears on demand, counts enabled cycles, flags the TIMEOUT-th one.
module seq_timeout #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

  // Asserted during the stalled cycle that would bring the count to TIMEOUT.
  assign expired = en && (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mmu_seq.sv
// Job-level sequencer driving the mmu weight/data/run/pop handshake chain.
module mmu_seq
  import mmu_pkg::*;
#(
  parameter int unsigned SIZE    = 2,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TW      = $clog2(TIMEOUT + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_reuse_w,
  input  logic [SIZE*SIZE*ELEM_W-1:0]  cmd_weight,
  input  logic [SIZE*SIZE*ELEM_W-1:0]  cmd_data,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [SIZE*SIZE*ACC_W-1:0]   res_acc,
  output logic                         err,
  input  logic                         new_weight_rdy,
  input  logic                         weight_ld_rdy,
  input  logic                         weight_ld_done,
  input  logic                         data_in_rdy,
  input  logic                         mult_rdy,
  input  logic                         mult_done,
  input  logic                         acc_out_rdy,
  output logic                         new_weight_push,
  output logic                         weight_ld_start,
  output logic                         weight_swap,
  output logic                         data_in_push,
  output logic                         mult_run,
  output logic                         acc_out_pop,
  output logic [SIZE*SIZE*ELEM_W-1:0]  new_weight_in,
  output logic [SIZE*SIZE*ELEM_W-1:0]  data_in,
  input  logic [SIZE*SIZE*ACC_W-1:0]   acc_out
);

  seq_state_t state_q, state_d;

  logic [SIZE*SIZE*ELEM_W-1:0] weight_q, data_q;
  logic [SIZE*SIZE*ACC_W-1:0]  res_acc_q;
  logic                        res_valid_q, err_q, wvalid_q;
  logic push_q, ld_q, swap_q, dpush_q, run_q, pop_q;
  logic push_d, ld_d, swap_d, dpush_d, run_d, pop_d;
  logic accept, cap, tmo_en, tmo_clr, tmo_exp;

  assign cmd_ready = !rst && (state_q == IDLE) && !res_valid_q && !err_q;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    push_d  = 1'b0;
    ld_d    = 1'b0;
    swap_d  = 1'b0;
    dpush_d = 1'b0;
    run_d   = 1'b0;
    pop_d   = 1'b0;
    cap     = 1'b0;
    tmo_en  = 1'b0;
    case (state_q)
      IDLE: begin
        // Reuse only makes sense once some job has installed weights.
        if (accept) state_d = (cmd_reuse_w && wvalid_q) ? D_PUSH : W_PUSH;
      end
      W_PUSH: begin
        tmo_en = !new_weight_rdy;
        if (new_weight_rdy) begin
          push_d  = 1'b1;
          state_d = W_LOAD;
        end
      end
      W_LOAD: begin
        tmo_en = !weight_ld_rdy;
        if (weight_ld_rdy) begin
          ld_d    = 1'b1;
          state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        tmo_en = !weight_ld_done;
        if (weight_ld_done) state_d = SWAP;
      end
      SWAP: begin
        swap_d  = 1'b1;
        state_d = D_PUSH;
      end
      D_PUSH: begin
        tmo_en = !data_in_rdy;
        if (data_in_rdy) begin
          dpush_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        tmo_en = !(mult_rdy && !mult_done);
        if (mult_rdy && !mult_done) begin
          run_d   = 1'b1;
          state_d = M_WAIT;
        end
      end
      M_WAIT: begin
        tmo_en = !mult_done;
        if (mult_done) state_d = POP;
      end
      POP: begin
        tmo_en = !acc_out_rdy;
        if (acc_out_rdy) begin
          pop_d   = 1'b1;
          state_d = CAP;
        end
      end
      CAP: begin
        cap     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = ERR;
    endcase
    if (tmo_exp) state_d = ERR;
    tmo_clr = (state_d != state_q);
  end

  seq_timeout #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      weight_q    <= '0;
      data_q      <= '0;
      res_acc_q   <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      wvalid_q    <= 1'b0;
      push_q      <= 1'b0;
      ld_q        <= 1'b0;
      swap_q      <= 1'b0;
      dpush_q     <= 1'b0;
      run_q       <= 1'b0;
      pop_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      push_q  <= push_d;
      ld_q    <= ld_d;
      swap_q  <= swap_d;
      dpush_q <= dpush_d;
      run_q   <= run_d;
      pop_q   <= pop_d;
      err_q   <= err_q || tmo_exp;
      if (accept) begin
        weight_q <= cmd_weight;
        data_q   <= cmd_data;
      end
      if (state_q == SWAP) wvalid_q <= 1'b1;
      if (cap) begin
        res_acc_q   <= acc_out;
        res_valid_q <= 1'b1;
      end else if (res_valid_q && res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign res_valid       = res_valid_q;
  assign res_acc         = res_acc_q;
  assign err             = err_q;
  assign new_weight_push = push_q;
  assign weight_ld_start = ld_q;
  assign weight_swap     = swap_q;
  assign data_in_push    = dpush_q;
  assign mult_run        = run_q;
  assign acc_out_pop     = pop_q;
  assign new_weight_in   = weight_q;
  assign data_in         = data_q;

endmodule

// File: tb/tb_mmu_seq.sv
// Bench for mmu_seq: behavioural mmu responder plus a job-level result scoreboard.
module tb_mmu_seq;

  localparam int unsigned SIZE    = 2;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned NW      = SIZE * SIZE * 8;
  localparam int unsigned NA      = SIZE * SIZE * 32;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_reuse_w;
  logic [NW-1:0] cmd_weight, cmd_data;
  logic res_valid, res_ready;
  logic [NA-1:0] res_acc;
  logic err;
  logic new_weight_rdy, weight_ld_rdy, weight_ld_done, data_in_rdy, mult_rdy, mult_done;
  logic acc_out_rdy;
  logic new_weight_push, weight_ld_start, weight_swap, data_in_push, mult_run, acc_out_pop;
  logic [NW-1:0] new_weight_in, data_in;
  logic [NA-1:0] acc_out;

  always #5 clk = ~clk;

  mmu_seq #(
    .SIZE    (SIZE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_reuse_w     (cmd_reuse_w),
    .cmd_weight      (cmd_weight),
    .cmd_data        (cmd_data),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_acc         (res_acc),
    .err             (err),
    .new_weight_rdy  (new_weight_rdy),
    .weight_ld_rdy   (weight_ld_rdy),
    .weight_ld_done  (weight_ld_done),
    .data_in_rdy     (data_in_rdy),
    .mult_rdy        (mult_rdy),
    .mult_done       (mult_done),
    .acc_out_rdy     (acc_out_rdy),
    .new_weight_push (new_weight_push),
    .weight_ld_start (weight_ld_start),
    .weight_swap     (weight_swap),
    .data_in_push    (data_in_push),
    .mult_run        (mult_run),
    .acc_out_pop     (acc_out_pop),
    .new_weight_in   (new_weight_in),
    .data_in         (data_in),
    .acc_out         (acc_out)
  );

  function automatic logic [NA-1:0] matmul(input logic [NW-1:0] w, input logic [NW-1:0] d);
    logic [NA-1:0] r;
    int unsigned s;
    r = '0;
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        s = 0;
        for (int k = 0; k < SIZE; k++) begin
          s += 32'(w[(i*SIZE+k)*8 +: 8]) * 32'(d[(k*SIZE+j)*8 +: 8]);
        end
        r[(i*SIZE+j)*32 +: 32] = s;
      end
    end
    return r;
  endfunction

  // mmu responder: random readiness gaps (never more than 3 in a row) plus test knobs.
  logic gate = 1'b1;
  int   lowrun = 0;
  logic force_hi = 1'b0, drdy_low = 1'b0, no_ld_done = 1'b0, no_mdone = 1'b0;
  logic [NW-1:0] sh_w, act_w, dat;
  logic [NA-1:0] acc_reg;
  logic ld_busy, ld_done_r, mul_busy, mul_done_r;
  int   ld_cnt, mul_cnt;
  logic g;

  always @(posedge clk) begin
    if ($urandom_range(3) == 0 && lowrun < 3) begin
      gate   <= 1'b0;
      lowrun <= lowrun + 1;
    end else begin
      gate   <= 1'b1;
      lowrun <= 0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      sh_w <= '0; act_w <= '0; dat <= '0; acc_reg <= '0;
      ld_busy <= 1'b0; ld_done_r <= 1'b0; mul_busy <= 1'b0; mul_done_r <= 1'b0;
      ld_cnt <= 0; mul_cnt <= 0;
    end else begin
      if (new_weight_push) sh_w <= new_weight_in;
      if (weight_ld_start) begin
        ld_busy <= 1'b1;
        ld_cnt  <= 2;
      end else if (ld_busy) begin
        ld_cnt <= ld_cnt - 1;
        if (ld_cnt == 1) begin
          ld_busy   <= 1'b0;
          ld_done_r <= 1'b1;
        end
      end
      if (weight_swap) begin
        act_w     <= sh_w;
        ld_done_r <= 1'b0;
      end
      if (data_in_push) dat <= data_in;
      if (mult_run) begin
        mul_busy <= 1'b1;
        mul_cnt  <= 3;
      end else if (mul_busy) begin
        mul_cnt <= mul_cnt - 1;
        if (mul_cnt == 1) begin
          mul_busy   <= 1'b0;
          mul_done_r <= 1'b1;
          acc_reg    <= matmul(act_w, dat);
        end
      end
      if (acc_out_pop) mul_done_r <= 1'b0;
    end
  end

  assign g              = gate || force_hi;
  assign new_weight_rdy = g && !ld_busy;
  assign weight_ld_rdy  = g && !ld_busy && !ld_done_r;
  assign weight_ld_done = ld_done_r && !no_ld_done;
  assign data_in_rdy    = g && !drdy_low;
  assign mult_rdy       = g && !mul_busy;
  assign mult_done      = mul_done_r && !no_mdone;
  assign acc_out_rdy    = g && mul_done_r;
  assign acc_out        = acc_reg;

  // Strobe monitor: ids 0..5 = push, load, swap, dpush, run, pop.
  logic [5:0] strb, prev_strb = '0;
  int sq[$];
  int dbl = 0, acc_cnt = 0;
  assign strb = {acc_out_pop, mult_run, data_in_push, weight_swap, weight_ld_start,
                 new_weight_push};

  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) if (strb[i]) sq.push_back(i);
    if ((strb & prev_strb) != 6'd0) dbl <= dbl + 1;
    prev_strb <= strb;
  end

  always @(posedge clk) if (!rst && cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;

  int checks = 0, errors = 0;
  logic [NW-1:0] eff_w = '0;
  logic have_w = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic int count_id(input int id);
    int c;
    c = 0;
    foreach (sq[i]) if (sq[i] == id) c++;
    return c;
  endfunction

  function automatic logic [23:0] order_code();
    logic [23:0] o;
    o = '0;
    foreach (sq[i]) o = {o[19:0], 4'(sq[i])};
    return o;
  endfunction

  task automatic send(input logic [NW-1:0] w, input logic [NW-1:0] d, input logic reuse,
                      output logic [NA-1:0] exp);
    int n;
    n = 0;
    cmd_weight  = w;
    cmd_data    = d;
    cmd_reuse_w = reuse;
    cmd_valid   = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 128'(n < 100), 128'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (!(reuse && have_w)) begin
      eff_w  = w;
      have_w = 1'b1;
    end
    exp = matmul(eff_w, d);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("res_arrive", 128'(res_valid), 128'd1);
  endtask

  task automatic get_result(input logic [NA-1:0] exp, input string tag);
    wait_valid();
    repeat ($urandom_range(2)) @(negedge clk);
    check(tag, res_acc, exp);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    check({tag, "_clr"}, 128'(res_valid), 128'd0);
  endtask

  localparam logic [NW-1:0] W1 = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [NW-1:0] D1 = {8'd8, 8'd7, 8'd6, 8'd5};
  localparam logic [NW-1:0] ID = {8'd1, 8'd0, 8'd0, 8'd1};
  localparam logic [NA-1:0] R1 = {32'h32, 32'h2B, 32'h16, 32'h13};
  localparam logic [NA-1:0] RW = {32'd4, 32'd3, 32'd2, 32'd1};

  initial begin
    logic [NA-1:0] exp, exp_a, snap;
    logic [NW-1:0] wb, db;
    logic ok;
    int n, a0;

    rst = 1'b1; cmd_valid = 1'b0; cmd_reuse_w = 1'b0; cmd_weight = '0; cmd_data = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 128'(cmd_ready), 128'd0);
    check("rst_res_valid", 128'(res_valid), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    check("rst_res_acc", res_acc, 128'd0);
    check("rst_strobes", 128'(strb), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", 128'(cmd_ready), 128'd1);

    // Directed non-reuse job.
    sq.delete();
    send(W1, D1, 1'b0, exp);
    get_result(R1, "t1_res");
    repeat (2) @(negedge clk);
    check("t1_nstrobes", 128'(sq.size()), 128'd6);
    check("t1_order", 128'(order_code()), 128'h012345);

    // Reuse job keeps the active weights.
    sq.delete();
    send({4{8'd9}}, ID, 1'b1, exp);
    get_result(RW, "t2_res");
    repeat (2) @(negedge clk);
    check("t2_nstrobes", 128'(sq.size()), 128'd3);
    check("t2_order", 128'(order_code()), 128'h345);

    // Result held while res_ready is low; queued command waits for the handshake.
    send(128'($urandom), 128'($urandom), 1'b0, exp_a);
    wait_valid();
    wb = NW'($urandom); db = NW'($urandom);
    cmd_weight = wb; cmd_data = db; cmd_reuse_w = 1'b0; cmd_valid = 1'b1;
    snap = res_acc; a0 = acc_cnt; ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(res_valid === 1'b1 && res_acc === snap && cmd_ready === 1'b0)) ok = 1'b0;
    end
    check("t3_held_stable", 128'(ok), 128'd1);
    check("t3_res", res_acc, exp_a);
    check("t3_no_accept", 128'(acc_cnt - a0), 128'd0);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    send(wb, db, 1'b0, exp);
    get_result(exp, "t3_second");

    // Randomised jobs against the job-level scoreboard.
    for (int j = 0; j < 25; j++) begin
      send(NW'($urandom), NW'($urandom), 1'($urandom_range(1)), exp);
      get_result(exp, "rand_res");
    end

    // data_in_rdy low for 10 cycles.
    force_hi = 1'b1; drdy_low = 1'b1;
    sq.delete();
    send(NW'($urandom), NW'($urandom), 1'b1, exp);
    repeat (10) @(negedge clk);
    check("t5_no_dpush", 128'(count_id(3)), 128'd0);
    drdy_low = 1'b0;
    check("t5_dpush_before", 128'(data_in_push), 128'd0);
    @(negedge clk);
    check("t5_dpush_pulse", 128'(data_in_push), 128'd1);
    @(negedge clk);
    check("t5_dpush_after", 128'(data_in_push), 128'd0);
    get_result(exp, "t5_res");
    check("t5_dpush_once", 128'(count_id(3)), 128'd1);

    // Reset mid-job in W_WAIT.
    no_ld_done = 1'b1;
    send(NW'($urandom), NW'($urandom), 1'b0, exp);
    n = 0;
    while (!weight_ld_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_wwait", 128'(weight_ld_start), 128'd1);
    rst = 1'b1; have_w = 1'b0;
    @(negedge clk);
    check("t6_rst_strobes", 128'(strb), 128'd0);
    check("t6_rst_res_valid", 128'(res_valid), 128'd0);
    rst = 1'b0; no_ld_done = 1'b0;
    @(negedge clk);
    check("t6_idle", 128'(cmd_ready), 128'd1);
    sq.delete();
    send(NW'($urandom), NW'($urandom), 1'b1, exp);
    get_result(exp, "t6_fresh_res");
    check("t6_weight_push", 128'(count_id(0)), 128'd1);

    // mult_done never arrives: timeout after 16 cycles in M_WAIT.
    no_mdone = 1'b1;
    send(NW'($urandom), NW'($urandom), 1'b1, exp);
    n = 0;
    while (!mult_run && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t7_reach_mwait", 128'(mult_run), 128'd1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) check("t7_err_early", 128'(err), 128'd0);
      if (k == 16) check("t7_err_set", 128'(err), 128'd1);
    end
    cmd_valid = 1'b1; a0 = acc_cnt; ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || strb !== 6'd0 || err !== 1'b1) ok = 1'b0;
    end
    check("t7_err_terminal", 128'(ok), 128'd1);
    check("t7_no_accept", 128'(acc_cnt - a0), 128'd0);
    cmd_valid = 1'b0;
    rst = 1'b1; no_mdone = 1'b0; have_w = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t7_err_cleared", 128'(err), 128'd0);
    check("t7_cmd_ready", 128'(cmd_ready), 128'd1);

    check("no_double_pulse", 128'(dbl), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
